riscv_fetch_queue: RTL

RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

---
 rtl/riscv_fetch_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue in front of a fixed
// one-cycle-latency icache; handles redirects, global stall and wrap-around PCs.
module riscv_fetch_queue #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [31:0]         icache_addr,
  output logic                icache_re,
  input  logic [31:0]         instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [PC_WIDTH-1:0] out_next_pc
);

  localparam int                  PTR_W   = $clog2(DEPTH);
  localparam int                  CNT_W   = PTR_W + 1;
  localparam logic [31:0]         NOP     = 32'd19;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] fetch_pc_r;
  logic                inflight_r;
  logic [PC_WIDTH-1:0] inflight_pc_r;
  logic [31:0]         inst_mem_r [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [31:0]         out_inst_r;
  logic [PC_WIDTH-1:0] out_pc_r;
  logic [PC_WIDTH-1:0] out_next_pc_r;

  logic                pop_s;
  logic                push_s;
  logic                issue_s;
  logic [CNT_W-1:0]    occ_s;
  logic [CNT_W-1:0]    count_nxt_s;
  logic [PTR_W-1:0]    rd_ptr_nxt_s;
  logic [31:0]         head_inst_s;
  logic [PC_WIDTH-1:0] head_pc_s;

  // Handshake, credit check and next head selection.
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    issue_s      = 1'b0;
    occ_s        = count_r;
    count_nxt_s  = count_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_inst_s  = NOP;
    head_pc_s    = out_pc_r;

    pop_s  = (count_r != {CNT_W{1'b0}}) & out_ready & ~stall & ~redirect;
    // A response is captured even under stall; redirect and reset kill it.
    push_s = inflight_r & ~redirect & ~rst;
    // Counting the outstanding response guarantees it always finds a free slot.
    occ_s   = count_r + CNT_W'(inflight_r) - CNT_W'(pop_s);
    issue_s = ~rst & ~stall & ~redirect & (occ_s < DEPTH_C);

    count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    // Output registers load the post-edge head; the bypass covers a write into an empty queue.
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      head_inst_s = NOP;
      head_pc_s   = out_pc_r;
    end else if ((count_r - CNT_W'(pop_s)) == {CNT_W{1'b0}}) begin
      head_inst_s = instruction;
      head_pc_s   = inflight_pc_r;
    end else begin
      head_inst_s = inst_mem_r[rd_ptr_nxt_s];
      head_pc_s   = pc_mem_r[rd_ptr_nxt_s];
    end
  end

  // Queue storage; contents beyond count are never visible, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wr_ptr_r] <= instruction;
      pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
    end
  end

  // Fetch PC, inflight tracking, queue pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_PC;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      out_inst_r    <= NOP;
      out_pc_r      <= RESET_PC;
      out_next_pc_r <= RESET_PC + PC_STEP;
    end else if (redirect) begin
      fetch_pc_r <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      inflight_r <= 1'b0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      out_inst_r <= NOP;
    end else begin
      if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + PC_STEP;
        inflight_pc_r <= fetch_pc_r;
      end
      inflight_r <= issue_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r      <= rd_ptr_nxt_s;
      count_r       <= count_nxt_s;
      out_inst_r    <= head_inst_s;
      out_pc_r      <= head_pc_s;
      out_next_pc_r <= head_pc_s + PC_STEP;
    end
  end

  assign icache_re   = issue_s;
  assign icache_addr = 32'(fetch_pc_r);
  assign out_valid   = (count_r != {CNT_W{1'b0}});
  assign out_inst    = out_inst_r;
  assign out_pc      = out_pc_r;
  assign out_next_pc = out_next_pc_r;

endmodule
